// File: rtl/maxnet_scheduler_pkg.sv
// Shared types and widths for the Maxnet layer scheduler.
// The FSM states and the activation/accumulator widths are shared with the datapath.
package maxnet_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int ACT_W = 5;
  localparam int ACC_W = 12;

endpackage

// File: rtl/maxnet_iter_counter.sv
// Saturating iteration counter for the Maxnet scheduler.
// tc_o flags that the next increment lands on MAX_ITER, so the FSM can stop in the same cycle.
module maxnet_iter_counter #(
  parameter int MAX_ITER = 15,
  parameter int ITW      = $clog2(MAX_ITER + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           inc_i,
  output logic [ITW-1:0] count_o,
  output logic           tc_o
);

  localparam logic [ITW-1:0] MAX_C  = ITW'(MAX_ITER);
  localparam logic [ITW-1:0] LAST_C = ITW'(MAX_ITER - 1);

  logic [ITW-1:0] count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX_C)) begin
      count_d = count_q + 1'b1;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == LAST_C);

endmodule

// File: rtl/maxnet_scheduler.sv
// Maxnet layer scheduler: time-shares one MAC and one activation unit over all neurons,
// writes a shadow bank per iteration and commits it, stopping on a single survivor or the cap.
module maxnet_scheduler
  import maxnet_scheduler_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 4,
  parameter int MAX_ITER    = 15,
  parameter int NW          = $clog2(NUM_NEURONS),
  parameter int IW          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter int ITW         = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACT_W-1:0] act_out,
  output logic [NW-1:0]    sel_neuron,
  output logic [IW-1:0]    sel_input,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             wr_en,
  output logic [NW-1:0]    wr_addr,
  output logic             commit,
  output logic             busy,
  output logic             done,
  output logic [NW-1:0]    winner,
  output logic             winner_valid,
  output logic [ITW-1:0]   iter_count
);

  localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURONS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_INPUTS - 1);

  state_t        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [IW-1:0] i_q, i_d;
  logic [1:0]    nz_cnt_q, nz_cnt_d;
  logic [NW-1:0] last_nz_q, last_nz_d;
  logic [NW-1:0] winner_q, winner_d;
  logic          winner_valid_q, winner_valid_d;

  logic          cnt_clr, cnt_inc, cnt_tc;
  logic [ITW-1:0] cnt_value;

  maxnet_iter_counter #(
    .MAX_ITER (MAX_ITER),
    .ITW      (ITW)
  ) u_iter_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (cnt_value),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      n_q            <= '0;
      i_q            <= '0;
      nz_cnt_q       <= '0;
      last_nz_q      <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      i_q            <= i_d;
      nz_cnt_q       <= nz_cnt_d;
      last_nz_q      <= last_nz_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    i_d            = i_q;
    nz_cnt_d       = nz_cnt_q;
    last_nz_d      = last_nz_q;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = CLEAR;
          n_d            = '0;
          i_d            = '0;
          nz_cnt_d       = '0;
          last_nz_d      = '0;
          winner_d       = '0;
          winner_valid_d = 1'b0;
          cnt_clr        = 1'b1;
        end
      end
      CLEAR: begin
        state_d = ACCUM;
        i_d     = '0;
      end
      ACCUM: begin
        if (i_q == I_LAST) begin
          state_d = WRITE;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      WRITE: begin
        if (act_out != '0) begin
          last_nz_d = n_q;
          if (nz_cnt_q != 2'd2) begin
            nz_cnt_d = nz_cnt_q + 2'd1;
          end
        end
        if (n_q == N_LAST) begin
          state_d = CHECK;
        end else begin
          n_d     = n_q + 1'b1;
          state_d = CLEAR;
        end
      end
      CHECK: begin
        cnt_inc = 1'b1;
        // Winner is captured here so it is already visible during the DONE pulse.
        if ((nz_cnt_q <= 2'd1) || cnt_tc) begin
          state_d        = DONE;
          winner_d       = (nz_cnt_q == 2'd0) ? '0 : last_nz_q;
          winner_valid_d = (nz_cnt_q == 2'd1);
        end else begin
          state_d  = CLEAR;
          n_d      = '0;
          nz_cnt_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    sel_neuron = '0;
    sel_input  = '0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    commit     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      CLEAR: begin
        busy       = 1'b1;
        acc_clr    = 1'b1;
        sel_neuron = n_q;
      end
      ACCUM: begin
        busy       = 1'b1;
        acc_en     = 1'b1;
        sel_neuron = n_q;
        sel_input  = i_q;
      end
      WRITE: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = n_q;
        sel_neuron = n_q;
      end
      CHECK: begin
        busy       = 1'b1;
        commit     = 1'b1;
        sel_neuron = n_q;
      end
      DONE: begin
        done       = 1'b1;
        sel_neuron = n_q;
      end
      default: begin
        sel_neuron = '0;
      end
    endcase
  end

  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;
  assign iter_count   = cnt_value;

endmodule

// File: tb/tb_maxnet_scheduler.sv
// Scoreboard bench for maxnet_scheduler: each run's expected per-cycle output trace is
// derived from the layer rules and checked by an independent negedge monitor.
module tb_maxnet_scheduler;

  localparam int NN  = 4;
  localparam int NI  = 4;
  localparam int MI  = 15;
  localparam int NW  = 2;
  localparam int IW  = 2;
  localparam int ITW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [4:0]     act_out = '0;
  logic [NW-1:0]  sel_neuron;
  logic [IW-1:0]  sel_input;
  logic           acc_clr, acc_en, wr_en, commit, busy, done, winner_valid;
  logic [NW-1:0]  wr_addr, winner;
  logic [ITW-1:0] iter_count;

  maxnet_scheduler #(
    .NUM_NEURONS (NN),
    .NUM_INPUTS  (NI),
    .MAX_ITER    (MI)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .act_out      (act_out),
    .sel_neuron   (sel_neuron),
    .sel_input    (sel_input),
    .acc_clr      (acc_clr),
    .acc_en       (acc_en),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .commit       (commit),
    .busy         (busy),
    .done         (done),
    .winner       (winner),
    .winner_valid (winner_valid),
    .iter_count   (iter_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           acc_clr;
    logic           acc_en;
    logic           wr_en;
    logic           commit;
    logic           busy;
    logic           done;
    logic           winner_valid;
    logic [NW-1:0]  sel_neuron;
    logic [IW-1:0]  sel_input;
    logic [NW-1:0]  wr_addr;
    logic [NW-1:0]  winner;
    logic [ITW-1:0] iter_count;
    logic           care_sn;
    logic           care_si;
    logic           care_wa;
  } exp_t;

  exp_t sb_q[$];
  exp_t base;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   run_id = 0;

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.care_sn = 1'b1;
    e.care_si = 1'b1;
    return e;
  endfunction

  // Monitor: one expected entry per cycle from the scoreboard, otherwise the idle baseline.
  always @(negedge clk) begin
    exp_t e, a;
    cyc++;
    if (mon_en) begin
      e = (sb_q.size() > 0) ? sb_q.pop_front() : base;
      a = '0;
      a.acc_clr      = acc_clr;
      a.acc_en       = acc_en;
      a.wr_en        = wr_en;
      a.commit       = commit;
      a.busy         = busy;
      a.done         = done;
      a.winner_valid = winner_valid;
      a.sel_neuron   = e.care_sn ? sel_neuron : e.sel_neuron;
      a.sel_input    = e.care_si ? sel_input  : e.sel_input;
      a.wr_addr      = e.care_wa ? wr_addr    : e.wr_addr;
      a.winner       = winner;
      a.iter_count   = iter_count;
      a.care_sn      = e.care_sn;
      a.care_si      = e.care_si;
      a.care_wa      = e.care_wa;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d got clr=%b en=%b wr=%b cm=%b busy=%b done=%b sn=%0d si=%0d wa=%0d win=%0d wv=%b it=%0d required clr=%b en=%b wr=%b cm=%b busy=%b done=%b sn=%0d si=%0d wa=%0d win=%0d wv=%b it=%0d",
                 cyc, a.acc_clr, a.acc_en, a.wr_en, a.commit, a.busy, a.done, a.sel_neuron, a.sel_input,
                 a.wr_addr, a.winner, a.winner_valid, a.iter_count,
                 e.acc_clr, e.acc_en, e.wr_en, e.commit, e.busy, e.done, e.sel_neuron, e.sel_input,
                 e.wr_addr, e.winner, e.winner_valid, e.iter_count);
      end
      if (e.done) begin
        base = e;
        base.done    = 1'b0;
        base.care_sn = 1'b1;
        base.care_si = 1'b1;
        base.care_wa = 1'b0;
      end
    end
  end

  task automatic check_all_zero(input string name);
    logic [20:0] all_out;
    all_out = {sel_neuron, sel_input, acc_clr, acc_en, wr_en, wr_addr, commit, busy, done,
               winner, winner_valid, iter_count};
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL %s outputs=%h required 0", name, all_out);
    end
  endtask

  // mode 0: only neuron 2 fires; 1: every neuron 5'h1F; 2: all zero; 3: random with pct% nonzero.
  task automatic run_case(input int mode, input int pct, input bit do_reset);
    logic [4:0] tab [MI][NN];
    exp_t       tr[$];
    logic [4:0] drv[$];
    exp_t       e;
    int         iters, nz, lw, win;
    bit         wv;

    for (int k = 0; k < MI; k++) begin
      for (int j = 0; j < NN; j++) begin
        case (mode)
          0:       tab[k][j] = (j == 2) ? 5'($urandom_range(1, 31)) : 5'd0;
          1:       tab[k][j] = 5'h1F;
          2:       tab[k][j] = 5'd0;
          default: tab[k][j] = ($urandom_range(0, 99) < pct) ? 5'($urandom_range(1, 31)) : 5'd0;
        endcase
      end
    end

    iters = 0;
    nz = 0;
    lw = 0;
    for (int k = 0; k < MI; k++) begin
      nz = 0;
      lw = 0;
      for (int j = 0; j < NN; j++) begin
        if (tab[k][j] != 0) begin
          nz++;
          lw = j;
        end
      end
      iters = k + 1;
      if (nz <= 1) break;
    end
    win = (nz == 0) ? 0 : lw;
    wv  = (nz == 1);

    for (int k = 0; k < iters; k++) begin
      for (int j = 0; j < NN; j++) begin
        e = '0;
        e.busy       = 1'b1;
        e.iter_count = ITW'(k);
        e.sel_neuron = NW'(j);
        e.care_sn    = 1'b1;
        e.acc_clr    = 1'b1;
        tr.push_back(e);
        drv.push_back(5'($urandom_range(0, 31)));
        e.acc_clr = 1'b0;
        e.acc_en  = 1'b1;
        e.care_si = 1'b1;
        for (int i = 0; i < NI; i++) begin
          e.sel_input = IW'(i);
          tr.push_back(e);
          drv.push_back(5'($urandom_range(0, 31)));
        end
        e.acc_en    = 1'b0;
        e.care_si   = 1'b0;
        e.sel_input = '0;
        e.wr_en     = 1'b1;
        e.wr_addr   = NW'(j);
        e.care_wa   = 1'b1;
        tr.push_back(e);
        drv.push_back(tab[k][j]);
      end
      e = '0;
      e.busy       = 1'b1;
      e.commit     = 1'b1;
      e.iter_count = ITW'(k);
      tr.push_back(e);
      drv.push_back(5'($urandom_range(0, 31)));
    end
    e = '0;
    e.done         = 1'b1;
    e.winner       = NW'(win);
    e.winner_valid = wv;
    e.iter_count   = ITW'(iters);
    tr.push_back(e);
    drv.push_back(5'($urandom_range(0, 31)));

    run_id++;
    $display("run %0d mode=%0d iters=%0d winner=%0d winner_valid=%0b reset_mid=%0b",
             run_id, mode, do_reset ? 0 : iters, win, wv, do_reset);

    @(posedge clk);
    #1;
    start   = 1'b1;
    act_out = 5'($urandom_range(0, 31));
    @(posedge clk);
    #1;
    foreach (tr[c]) sb_q.push_back(tr[c]);
    for (int c = 0; c < tr.size(); c++) begin
      start   = (c == tr.size() - 1) ? 1'b1 : (tr[c].acc_en && ($urandom_range(0, 7) == 0));
      act_out = drv[c];
      if (do_reset && c == 3) begin
        #2;
        mon_en = 1'b0;
        start  = 1'b0;
        rst    = 1'b1;
        #1;
        check_all_zero("reset_mid_accum");
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        sb_q.delete();
        base   = idle_exp();
        mon_en = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  initial begin
    base = idle_exp();
    rst  = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("in_reset");
    @(posedge clk);
    #3;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    run_case(0, 0, 1'b0);
    run_case(2, 0, 1'b0);
    run_case(1, 0, 1'b0);
    run_case(3, 60, 1'b1);
    run_case(0, 0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      run_case(3, $urandom_range(20, 90), 1'b0);
    end
    run_case(1, 0, 1'b0);
    run_case(2, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
